// File: rtl/ahb_slv_pkg.sv
// ahb_slv_pkg
// Shared encodings for the AHB slave memory: transfer types, responses,
// transfer sizes and the data-phase state machine states.
package ahb_slv_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } slv_state_e;

endpackage

// File: rtl/ahb_slv_byte_en.sv
// ahb_slv_byte_en
// Combinational byte-lane enable generator for one AHB data beat.
// Ports:
//   size    - hsize of the transfer (2**size bytes)
//   addr_lo - byte offset of the transfer within the bus word
//   byte_en - one bit per byte lane of the DATA_WIDTH-bit bus
// Only meaningful for legal, aligned transfers; illegal ones are
// rejected before they ever reach a memory write.
module ahb_slv_byte_en #(
    parameter  int DATA_WIDTH = 32,
    localparam int NB         = DATA_WIDTH / 8,
    localparam int LANE_BITS  = $clog2(NB)
) (
    input  logic [2:0]           size,
    input  logic [LANE_BITS-1:0] addr_lo,
    output logic [NB-1:0]        byte_en
);

    logic [NB-1:0] mask;

    always_comb begin
        mask = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < (1 << size)) begin
                mask[i] = 1'b1;
            end
        end
        byte_en = mask << addr_lo;
    end

endmodule

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem
// AHB slave backed by a word-organised memory. Captures the address phase,
// inserts WAIT_CYCLES wait states per legal transfer, writes with byte-lane
// enables and answers illegal accesses with the two-cycle ERROR response.
// Ports:
//   hclk, hresetn       - bus clock, asynchronous active-low reset
//   hsel, haddr, htrans - address phase select / address / transfer type
//   hburst              - burst type (not used; addresses come from haddr)
//   hsize, hwrite       - transfer size and direction
//   hwdata              - write data, valid in the data phase
//   hready              - bus-level ready (hreadyin)
//   hreadyout, hresp    - slave ready and response
//   hrdata              - read data
//
// state    | meaning
// ST_IDLE  | no transfer in data phase; zero-wait OKAY
// ST_WAIT  | legal transfer stalled; counter runs down to 0
// ST_DONE  | legal transfer completing; memory accessed this cycle
// ST_ERR1  | first ERROR cycle, hreadyout low
// ST_ERR2  | second ERROR cycle, hreadyout high
module ahb_slave_mem
    import ahb_slv_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_DEPTH   = 1024,
    parameter int unsigned           WAIT_CYCLES = 0,
    parameter logic [ADDR_WIDTH-1:0] ERR_ADDR_LO = 'h0000_0F00,
    parameter logic [ADDR_WIDTH-1:0] ERR_ADDR_HI = 'h0000_0FFF
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic [2:0]            hburst,
    input  logic [2:0]            hsize,
    input  logic                  hwrite,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hready,
    output logic                  hreadyout,
    output logic [1:0]            hresp,
    output logic [DATA_WIDTH-1:0] hrdata
);

    localparam int          NB        = DATA_WIDTH / 8;
    localparam int          LANE_BITS = $clog2(NB);
    localparam int          IDX_BITS  = $clog2(MEM_DEPTH);
    localparam logic [63:0] MEM_BYTES = 64'(MEM_DEPTH) * 64'(NB);
    localparam logic [2:0]  MAX_SIZE  = (DATA_WIDTH == 64) ? HSIZE_DWORD : HSIZE_WORD;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    slv_state_e            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            size_q;
    logic                  write_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] hrdata_q;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  data_ready;
    logic                  capture;
    logic                  err_in;
    logic [ADDR_WIDTH-1:0] align_mask;
    logic [IDX_BITS-1:0]   idx;
    logic [NB-1:0]         be;
    logic                  wr_en;
    logic                  rd_done;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  unused_ok;

    assign unused_ok = ^{hburst, addr_q[ADDR_WIDTH-1:IDX_BITS+LANE_BITS]};

    // The slave only accepts a new address phase in a cycle where it is
    // itself ready, so a held address phase during a stall is never taken
    // twice even if hready is not looped back from hreadyout.
    assign data_ready = (state_q != ST_WAIT) && (state_q != ST_ERR1);
    assign hreadyout  = data_ready;
    assign capture    = data_ready && hsel && hready &&
                        ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

    assign align_mask = (ADDR_WIDTH'(1) << hsize) - ADDR_WIDTH'(1);
    assign err_in     = ((haddr >= ERR_ADDR_LO) && (haddr <= ERR_ADDR_HI)) ||
                        (64'(haddr) >= MEM_BYTES) ||
                        (hsize > MAX_SIZE) ||
                        (|(haddr & align_mask));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hresp   = HRESP_OKAY;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ERR1: begin
                hresp   = HRESP_ERROR;
                state_d = ST_ERR2;
            end
            ST_ERR2: begin
                hresp = HRESP_ERROR;
            end
            default: ;
        endcase
        if (capture) begin
            if (err_in) begin
                state_d = ST_ERR1;
            end else if (WAIT_CYCLES > 0) begin
                state_d = ST_WAIT;
                cnt_d   = WAIT_LOAD;
            end else begin
                state_d = ST_DONE;
            end
        end else if (data_ready) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            size_q   <= 3'd0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            hrdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                addr_q  <= haddr;
                size_q  <= hsize;
                write_q <= hwrite;
                err_q   <= err_in;
            end
            if (rd_done) begin
                hrdata_q <= mem_rdata;
            end
        end
    end

    ahb_slv_byte_en #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_byte_en (
        .size    (size_q),
        .addr_lo (addr_q[LANE_BITS-1:0]),
        .byte_en (be)
    );

    assign idx       = addr_q[LANE_BITS +: IDX_BITS];
    assign mem_rdata = mem[idx];
    assign wr_en     = (state_q == ST_DONE) && write_q && !err_q;
    assign rd_done   = (state_q == ST_DONE) && !write_q && !err_q;

    // Read data is taken straight from the array in the completing cycle so
    // a write completing on the previous edge is already visible.
    assign hrdata = rd_done ? mem_rdata : hrdata_q;

    // No reset on the array: contents are undefined until written.
    always_ff @(posedge hclk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= hwdata[8*b +: 8];
                end
            end
        end
    end

endmodule
